// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline sequencing
//               controller: FSM state encoding, default drain length and the
//               hard-wired zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  // Halt travels through EX, MEM and WB before the core is considered stopped.
  localparam int DRAIN_CYCLES_DEF = 3;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Bundle between the decode/execute datapath and the pipeline
//               sequencing controller.
//               master : datapath side (drives hazard/halt/busy inputs)
//               slave  : controller side (drives enables, flushes, status)
//               Inputs : id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
//                        ex_mem_read, ex_rd, ex_redirect, mem_busy
//               Outputs: pc/ifid/idex/exmem/memwb_write, ifid/idex_flush,
//                        halted, state, stall_count, flush_count
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_halt;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic             mem_busy;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_write;
  logic             exmem_write;
  logic             memwb_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
           ex_mem_read, ex_rd, ex_redirect, mem_busy,
    input  pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, halted, state, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
           ex_mem_read, ex_rd, ex_redirect, mem_busy,
    output pc_write, ifid_write, idex_write, exmem_write, memwb_write,
           ifid_flush, idex_flush, halted, state, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use comparator. Flags when the load in EX
//               writes a register that the instruction in ID reads.
//               Inputs : ex_mem_read, ex_rd, id_rs1, id_rs2, id_use_rs1/2
//               Output : load_use
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  wire logic       ex_mem_read,
  input  wire logic [4:0] ex_rd,
  input  wire logic [4:0] id_rs1,
  input  wire logic [4:0] id_rs2,
  input  wire logic       id_use_rs1,
  input  wire logic       id_use_rs2,
  output logic            load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = id_use_rs1 && (ex_rd == id_rs1);
  assign w_rs2_hit = id_use_rs2 && (ex_rd == id_rs2);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign load_use = ex_mem_read && (ex_rd != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline sequencing controller for the 5-stage core. Produces
//               per-stage write enables and bubble flushes for load-use
//               stalls, redirects, memory-busy freezes and halt drain; owns
//               the halt FSM and saturating stall/flush event counters.
//               Ports  : clk, rst_n (async, active-low), bus (pipe_ctrl_if)
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  pipe_ctrl_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] C_DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  pipe_state_e      r_state;
  pipe_state_e      w_state_next;
  logic [DW-1:0]    r_drain_cnt;
  logic [DW-1:0]    w_drain_next;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_load_use;
  logic [4:0]       w_en;      // {pc, ifid, idex, exmem, memwb}
  logic [1:0]       w_flush;   // {ifid, idex}

  hazard_detect u_hazard (
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_use_rs1  (bus.id_use_rs1),
    .id_use_rs2  (bus.id_use_rs2),
    .load_use    (w_load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_drain_cnt   <= '0;
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      if (w_stall_inc && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
      if (w_flush_inc && (r_flush_count != '1)) r_flush_count <= r_flush_count + 1'b1;
    end
  end

  always_comb begin
    w_en         = 5'b00000;
    w_flush      = 2'b00;
    w_state_next = r_state;
    w_drain_next = r_drain_cnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    if (!rst_n) begin
      // Outputs follow the asynchronous reset directly, not the next edge.
      w_flush = 2'b11;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.mem_busy) begin
            w_stall_inc = 1'b1;
          end else if (bus.ex_redirect) begin
            // Younger instructions (including any halt or load-use) are wrong-path.
            w_en        = 5'b11111;
            w_flush     = 2'b11;
            w_flush_inc = 1'b1;
          end else if (w_load_use) begin
            w_en        = 5'b00111;
            w_flush     = 2'b01;
            w_stall_inc = 1'b1;
          end else if (bus.id_halt) begin
            w_en         = 5'b01111;
            w_flush      = 2'b10;
            w_state_next = DRAIN;
            w_drain_next = '0;
          end else begin
            w_en = 5'b11111;
          end
        end
        DRAIN: begin
          w_flush = 2'b11;
          if (!bus.mem_busy) begin
            w_en = 5'b01111;
            if (r_drain_cnt == C_DRAIN_LAST) w_state_next = HALTED;
            else                             w_drain_next = r_drain_cnt + DW'(1);
          end
        end
        HALTED: begin
          w_en = 5'b00000;
        end
        default: begin
          w_state_next = RUN;
        end
      endcase
    end
  end

  assign {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write, bus.memwb_write} = w_en;
  assign {bus.ifid_flush, bus.idex_flush} = w_flush;
  assign bus.halted      = (r_state == HALTED);
  assign bus.state       = r_state;
  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl (CNT_W=4,
//               DRAIN_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  pipe_ctrl_if #(.CNT_W(4)) bus ();

  pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [4:0] en;
  logic [1:0] fl;
  assign en = {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write, bus.memwb_write};
  assign fl = {bus.ifid_flush, bus.idex_flush};

  task automatic idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.id_halt = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd0;
    bus.ex_redirect = 1'b0; bus.mem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #3;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL rst_en actual=%b expected=%b", en, 5'b00000); end
    checks++; if (fl !== 2'b11) begin failures++; $display("FAIL rst_flush actual=%b expected=%b", fl, 2'b11); end
    checks++; if (bus.state !== 2'd0 || bus.halted !== 1'b0) begin failures++; $display("FAIL rst_state actual=%0d/%b expected=0/0", bus.state, bus.halted); end
    checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin failures++; $display("FAIL rst_cnt actual=%0d/%0d expected=0/0", bus.stall_count, bus.flush_count); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin failures++; $display("FAIL rst_release actual=%b/%b expected=11111/00", en, fl); end
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL rst_run actual=%0d expected=0", bus.state); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    #1;
    checks++; if (en !== 5'b00111 || fl !== 2'b01) begin failures++; $display("FAIL lu_rs1 actual=%b/%b expected=00111/01", en, fl); end
    tick();
    checks++; if (bus.stall_count !== 4'd1) begin failures++; $display("FAIL lu_cnt1 actual=%0d expected=1", bus.stall_count); end
    // rs2 path
    bus.id_use_rs1 = 1'b0; bus.id_rs1 = 5'd9; bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
    #1;
    checks++; if (en !== 5'b00111 || fl !== 2'b01) begin failures++; $display("FAIL lu_rs2 actual=%b/%b expected=00111/01", en, fl); end
    tick();
    checks++; if (bus.stall_count !== 4'd2) begin failures++; $display("FAIL lu_cnt2 actual=%0d expected=2", bus.stall_count); end
    // match but operand unused
    bus.id_use_rs2 = 1'b0;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin failures++; $display("FAIL lu_unused actual=%b/%b expected=11111/00", en, fl); end
    // destination x0 never stalls
    bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin failures++; $display("FAIL lu_x0 actual=%b/%b expected=11111/00", en, fl); end
    // not a load
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.ex_mem_read = 1'b0;
    #1;
    checks++; if (en !== 5'b11111) begin failures++; $display("FAIL lu_noload actual=%b expected=11111", en); end
    tick();
    checks++; if (bus.stall_count !== 4'd2) begin failures++; $display("FAIL lu_cnt_hold actual=%0d expected=2", bus.stall_count); end
  endtask

  task automatic test_mem_busy();
    do_reset();
    bus.mem_busy = 1'b1; bus.ex_redirect = 1'b1; bus.id_halt = 1'b1;
    #1;
    checks++; if (en !== 5'b00000 || fl !== 2'b00) begin failures++; $display("FAIL busy_out actual=%b/%b expected=00000/00", en, fl); end
    tick();
    checks++; if (bus.stall_count !== 4'd1 || bus.flush_count !== 4'd0 || bus.state !== 2'd0) begin failures++; $display("FAIL busy_upd actual=%0d/%0d/%0d expected=1/0/0", bus.stall_count, bus.flush_count, bus.state); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.ex_redirect = 1'b1; bus.id_halt = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs2 = 5'd3; bus.id_use_rs2 = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 2'b11) begin failures++; $display("FAIL redir_out actual=%b/%b expected=11111/11", en, fl); end
    tick();
    checks++; if (bus.state !== 2'd0) begin failures++; $display("FAIL redir_state actual=%0d expected=0", bus.state); end
    checks++; if (bus.flush_count !== 4'd1 || bus.stall_count !== 4'd0) begin failures++; $display("FAIL redir_cnt actual=%0d/%0d expected=1/0", bus.flush_count, bus.stall_count); end
  endtask

  task automatic test_halt();
    do_reset();
    bus.id_halt = 1'b1;
    #1;
    checks++; if (en !== 5'b01111 || fl !== 2'b10) begin failures++; $display("FAIL halt_accept actual=%b/%b expected=01111/10", en, fl); end
    tick();
    bus.id_halt = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd1 || bus.halted !== 1'b0) begin failures++; $display("FAIL halt_c1 actual=%0d/%b expected=1/0", bus.state, bus.halted); end
    checks++; if (en !== 5'b01111 || fl !== 2'b11) begin failures++; $display("FAIL drain_out actual=%b/%b expected=01111/11", en, fl); end
    // load-use and redirect are ignored while draining
    bus.ex_redirect = 1'b1;
    tick();
    bus.ex_redirect = 1'b0;
    tick();
    checks++; if (bus.state !== 2'd1 || bus.flush_count !== 4'd0) begin failures++; $display("FAIL halt_c3 actual=%0d/%0d expected=1/0", bus.state, bus.flush_count); end
    tick();
    checks++; if (bus.state !== 2'd2 || bus.halted !== 1'b1) begin failures++; $display("FAIL halt_c4 actual=%0d/%b expected=2/1", bus.state, bus.halted); end
    bus.id_halt = 1'b1; bus.ex_redirect = 1'b1; bus.mem_busy = 1'b1;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd4; bus.id_rs1 = 5'd4; bus.id_use_rs1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (en !== 5'b00000 || fl !== 2'b00 || bus.state !== 2'd2) begin failures++; $display("FAIL halted_hold actual=%b/%b/%0d expected=00000/00/2", en, fl, bus.state); end
      bus.mem_busy = ~bus.mem_busy;
      tick();
    end
    checks++; if (bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin failures++; $display("FAIL halted_cnt actual=%0d/%0d expected=0/0", bus.stall_count, bus.flush_count); end
  endtask

  task automatic test_halt_busy();
    do_reset();
    bus.id_halt = 1'b1;
    tick();
    bus.id_halt = 1'b0; bus.mem_busy = 1'b1;
    #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL hb_en1 actual=%b expected=00000", en); end
    tick();
    #1;
    checks++; if (en !== 5'b00000 || bus.state !== 2'd1) begin failures++; $display("FAIL hb_en2 actual=%b/%0d expected=00000/1", en, bus.state); end
    tick();
    bus.mem_busy = 1'b0;
    tick();
    tick();
    checks++; if (bus.state !== 2'd1) begin failures++; $display("FAIL hb_c5 actual=%0d expected=1", bus.state); end
    tick();
    checks++; if (bus.state !== 2'd2 || bus.halted !== 1'b1) begin failures++; $display("FAIL hb_c6 actual=%0d/%b expected=2/1", bus.state, bus.halted); end
    checks++; if (bus.stall_count !== 4'd0) begin failures++; $display("FAIL hb_stall actual=%0d expected=0", bus.stall_count); end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd12; bus.id_rs1 = 5'd12; bus.id_use_rs1 = 1'b1;
    repeat (14) tick();
    checks++; if (bus.stall_count !== 4'd14) begin failures++; $display("FAIL sat_14 actual=%0d expected=14", bus.stall_count); end
    repeat (6) tick();
    checks++; if (bus.stall_count !== 4'd15) begin failures++; $display("FAIL sat_15 actual=%0d expected=15", bus.stall_count); end
    checks++; if (en !== 5'b00111) begin failures++; $display("FAIL sat_en actual=%b expected=00111", en); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd2; bus.id_rs1 = 5'd2; bus.id_use_rs1 = 1'b1;
    tick();
    idle(); bus.ex_redirect = 1'b1;
    tick();
    idle(); bus.id_halt = 1'b1;
    tick();
    bus.id_halt = 1'b0;
    tick();
    checks++; if (bus.state !== 2'd1 || bus.stall_count !== 4'd1 || bus.flush_count !== 4'd1) begin failures++; $display("FAIL ar_pre actual=%0d/%0d/%0d expected=1/1/1", bus.state, bus.stall_count, bus.flush_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0 || bus.stall_count !== 4'd0 || bus.flush_count !== 4'd0) begin failures++; $display("FAIL ar_clear actual=%0d/%0d/%0d expected=0/0/0", bus.state, bus.stall_count, bus.flush_count); end
    checks++; if (en !== 5'b00000 || fl !== 2'b11) begin failures++; $display("FAIL ar_out actual=%b/%b expected=00000/11", en, fl); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    checks++; if (en !== 5'b11111 || fl !== 2'b00) begin failures++; $display("FAIL ar_release actual=%b/%b expected=11111/00", en, fl); end
    tick();
    checks++; if (bus.state !== 2'd0 || bus.halted !== 1'b0) begin failures++; $display("FAIL ar_run actual=%0d/%b expected=0/0", bus.state, bus.halted); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_busy();
    test_redirect();
    test_halt();
    test_halt_busy();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. Sits beside the main decoder and generates the per-stage write enables and flushes. It handles load-use stalls, taken branch/jump redirects, data-memory busy freezes and halt drain. It also owns the halt state machine and two saturating event counters for debug.

## Interface
Parameters:
- DRAIN_CYCLES, 3, number of un-frozen cycles after halt acceptance before `halted` asserts (halt in EX, MEM, WB).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- id_rs1, id_rs2  input  5  source register fields of the instruction in ID.
- id_use_rs1, id_use_rs2  input  1  instruction in ID reads rs1 / rs2.
- id_halt  input  1  decoder Halt for the instruction in ID.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_redirect  input  1  EX resolved a taken branch, JAL or JALR this cycle.
- mem_busy  input  1  data memory not ready; the whole pipeline must hold.
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  output  1 each  stage register enables.
- ifid_flush, idex_flush  output  1  load a bubble (all-zero control) into IF/ID / ID/EX.
- halted  output  1  core stopped, sticky until reset.
- state  output  2  current FSM state (RUN=0, DRAIN=1, HALTED=2).
- stall_count, flush_count  output  CNT_W  saturating event counters.

## Operation
- load_use = ex_mem_read && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
- Priority in RUN: mem_busy > ex_redirect > load_use > id_halt > normal.
  - mem_busy: all five enables 0, both flushes 0. No state or counter change except stall_count.
  - ex_redirect: all enables 1, ifid_flush=1, idex_flush=1. The PC loads the target through an external mux. flush_count+1. A simultaneous id_halt or load_use is wrong-path and ignored.
  - load_use: pc_write=0, ifid_write=0, idex_flush=1, other enables 1. stall_count+1.
  - id_halt (none of the above): all enables 1, pc_write=0, ifid_flush=1. Next state DRAIN with drain_cnt=0.
  - normal: all enables 1, flushes 0.
- DRAIN: pc_write=0, ifid_flush=1, idex_flush=1, other enables 1.
  - drain_cnt increments on each cycle without mem_busy.
  - mem_busy freezes all enables and drain_cnt.
  - When drain_cnt==DRAIN_CYCLES-1 on a non-busy cycle, next state is HALTED.
  - ex_redirect and load_use are ignored (cannot legally occur).
- HALTED: all enables 0, flushes 0, halted=1. All inputs ignored. Leaves only via reset.
- Counters saturate at 2^CNT_W-1 and never wrap. stall_count increments on RUN cycles with mem_busy or an accepted load_use.

## Timing
- All enable and flush outputs are combinational from the inputs and the registered state, in the same cycle. Zero latency.
- state, drain_cnt and the counters update on the rising clk edge. halted is decoded from the registered state.
- Reset (rst_n=0, asynchronous): state=RUN, drain_cnt=0, stall_count=0, flush_count=0, halted=0.
  - While rst_n=0, all enables are forced 0 and ifid_flush=idex_flush=1.
  - rst_n deassertion is synchronised externally. The first cycle after release is normal RUN.
- Reset mid-DRAIN or in HALTED returns to RUN with counters cleared.
- Halt acceptance to halted=1 takes exactly DRAIN_CYCLES+1 cycles with no mem_busy. Each mem_busy cycle adds one.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, DRAIN, HALTED) as a 2-bit typedef;
  - the DRAIN_CYCLES default;
  - the REG_X0 constant (5'd0).
- Sub-module hazard_detect: combinational load-use comparator producing load_use. Reusable by the forwarding unit.
- Top contains the priority mux, FSM, drain counter and the two counters.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_write=0, ifid_write=0, idex_flush=1, stall_count 0->1. Repeat with ex_rd=0 -> no stall.
- Redirect with simultaneous load_use and id_halt -> ifid_flush=idex_flush=1, pc_write=1, state stays RUN, flush_count=1, stall_count unchanged.
- Halt, no busy: id_halt=1 at cycle 0 -> state DRAIN at cycle 1, HALTED and halted=1 at cycle 4. All enables 0 afterwards, regardless of inputs.
- Halt with mem_busy=1 for 2 cycles during DRAIN -> halted at cycle 6. All enables 0 on busy cycles.
- Saturation: with CNT_W=4, hold load_use for 20 cycles -> stall_count reaches 15 and stays there.
- Async reset asserted mid-DRAIN, between clock edges -> state=RUN, counters 0 immediately. Enables 0 and flushes 1 while low; normal RUN after release.
